id_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the IF stage. It consumes the fetched instruction and pc_plus_four, and contains the IF/ID register, the 32x32 register file, the main control decoder, branch resolution, hazard detection and the ID/EX register. Its outputs drive the EX stage. It also returns pc_src, branch_addr and pc_write to the IF stage, which gates its PC update with pc_write.

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/reg_file.sv | 51 +++++
 rtl/id_stage.sv | 161 ++++++++++++++++
 tb/tb_id_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS ID stage: opcodes, ALU-op encodings,
// the ID/EX control bundle and the control decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } id_ex_ctrl_t;

    // Unknown opcodes decode to an all-zero bundle, i.e. a bubble.
    function automatic id_ex_ctrl_t decode_ctrl(input logic [5:0] opcode);
        id_ex_ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_OP_FUNCT;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALU_OP_ADD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALU_OP_ADD;
            end
            OP_BEQ: begin
                c.alu_op = ALU_OP_SUB;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_OP_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file with r0 hardwired to zero.
// Optional write-through bypass when ID_REGFILE_BYPASS_EN is defined.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [REG_AW-1:0] i_ra1,
    input  logic [REG_AW-1:0] i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2
);

    localparam int NREGS = 2 ** REG_AW;

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] ra);
        logic [DATA_W-1:0] v;
        v = '0;
        if (ra != '0) begin
`ifdef ID_REGFILE_BYPASS_EN
            if (i_we && (i_wa == ra)) v = i_wd;
            else                      v = r_regs[ra];
`else
            v = r_regs[ra];
`endif
        end
        return v;
    endfunction

    always_comb begin
        o_rd1 = read_port(i_ra1);
        o_rd2 = read_port(i_ra2);
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file, control decode,
// beq resolution, load-use/branch hazard stall and ID/EX register. Option: ID_REGFILE_BYPASS_EN.
module id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_instruction,
    input  logic [DATA_W-1:0] if_pc_plus_four,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              ex_mem_mem_read,
    input  logic [REG_AW-1:0] ex_mem_rd,
    output logic              pc_write,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_addr,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_to_reg,
    output logic              id_ex_mem_read,
    output logic              id_ex_mem_write,
    output logic              id_ex_alu_src,
    output logic              id_ex_reg_dst,
    output logic [1:0]        id_ex_alu_op,
    output logic [DATA_W-1:0] id_ex_read_data_1,
    output logic [DATA_W-1:0] id_ex_read_data_2,
    output logic [DATA_W-1:0] id_ex_imm_ext,
    output logic [REG_AW-1:0] id_ex_rs,
    output logic [REG_AW-1:0] id_ex_rt,
    output logic [REG_AW-1:0] id_ex_rd,
    output logic [DATA_W-1:0] id_ex_pc_plus_four
);

    logic [31:0]       r_if_id_instr;
    logic [DATA_W-1:0] r_if_id_pc4;

    id_ex_ctrl_t       r_ctrl;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_pc4;

    logic [5:0]        w_opcode;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_imm_ext;
    id_ex_ctrl_t       w_ctrl;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_is_beq;
    logic              w_uses_rt;
    logic [REG_AW-1:0] w_ex_dest;
    logic              w_load_use;
    logic              w_branch_haz;
    logic              w_stall;
    logic              w_taken;

    assign w_opcode  = r_if_id_instr[31:26];
    assign w_rs      = r_if_id_instr[25:21];
    assign w_rt      = r_if_id_instr[20:16];
    assign w_rd      = r_if_id_instr[15:11];
    assign w_imm     = r_if_id_instr[15:0];
    assign w_imm_ext = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign w_ctrl    = decode_ctrl(w_opcode);

    reg_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .i_we  (wb_reg_write),
        .i_wa  (wb_write_reg),
        .i_wd  (wb_write_data),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    assign w_is_beq  = (w_opcode == OP_BEQ);
    assign w_uses_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) || w_is_beq;
    assign w_ex_dest = r_ctrl.reg_dst ? r_rd : r_rt;

    // Loads resolve in MEM, so a dependent consumer in ID must wait one cycle.
    assign w_load_use = r_ctrl.mem_read && (r_rt != '0) &&
                        ((r_rt == w_rs) || (w_uses_rt && (r_rt == w_rt)));

    // beq compares in ID, so any producer still in EX or a load in MEM stalls it.
    assign w_branch_haz = w_is_beq && (
        (r_ctrl.reg_write && (w_ex_dest != '0) &&
            ((w_ex_dest == w_rs) || (w_ex_dest == w_rt))) ||
        (ex_mem_mem_read && (ex_mem_rd != '0) &&
            ((ex_mem_rd == w_rs) || (ex_mem_rd == w_rt))));

    assign w_stall = w_load_use || w_branch_haz;
    assign w_taken = w_is_beq && !w_stall && (w_rd1 == w_rd2);

    assign pc_write    = !w_stall;
    assign pc_src      = w_taken;
    assign branch_addr = r_if_id_pc4 + {w_imm_ext[DATA_W-3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= '0;
        end else if (w_stall) begin
            r_if_id_instr <= r_if_id_instr;
            r_if_id_pc4   <= r_if_id_pc4;
        end else if (w_taken) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= '0;
        end else begin
            r_if_id_instr <= if_instruction;
            r_if_id_pc4   <= if_pc_plus_four;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_stall) begin
            r_ctrl <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_rs   <= '0;
            r_rt   <= '0;
            r_rd   <= '0;
            r_pc4  <= '0;
        end else begin
            r_ctrl <= w_ctrl;
            r_rd1  <= w_rd1;
            r_rd2  <= w_rd2;
            r_imm  <= w_imm_ext;
            r_rs   <= w_rs;
            r_rt   <= w_rt;
            r_rd   <= w_rd;
            r_pc4  <= r_if_id_pc4;
        end
    end

    assign id_ex_reg_write    = r_ctrl.reg_write;
    assign id_ex_mem_to_reg   = r_ctrl.mem_to_reg;
    assign id_ex_mem_read     = r_ctrl.mem_read;
    assign id_ex_mem_write    = r_ctrl.mem_write;
    assign id_ex_alu_src      = r_ctrl.alu_src;
    assign id_ex_reg_dst      = r_ctrl.reg_dst;
    assign id_ex_alu_op       = r_ctrl.alu_op;
    assign id_ex_read_data_1  = r_rd1;
    assign id_ex_read_data_2  = r_rd2;
    assign id_ex_imm_ext      = r_imm;
    assign id_ex_rs           = r_rs;
    assign id_ex_rt           = r_rt;
    assign id_ex_rd           = r_rd;
    assign id_ex_pc_plus_four = r_pc4;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, regfile write/bypass, load-use and
// branch hazards, taken/not-taken beq with flush, r0 and reset-during-stall.
module tb_id_stage;

    localparam logic [31:0] I_ADD_R3_R5_R0 = 32'h00A0_1820;
    localparam logic [31:0] I_SUB_R1_R7_R0 = 32'h00E0_0822;
    localparam logic [31:0] I_LW_R2_0_R1   = 32'h8C22_0000;
    localparam logic [31:0] I_ADD_R4_R2_R3 = 32'h0043_2020;
    localparam logic [31:0] I_BEQ_R1_R2_3  = 32'h1022_0003;
    localparam logic [31:0] I_ADDI_R9_7    = 32'h2009_0007;
    localparam logic [31:0] I_ADDI_R1_4    = 32'h2001_0004;
    localparam logic [31:0] I_BEQ_R1_R0_1  = 32'h1020_0001;
    localparam logic [31:0] I_ADD_R6_R0_R0 = 32'h0000_3020;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_plus_four;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_mem_mem_read;
    logic [4:0]  ex_mem_rd;
    logic        pc_write;
    logic        pc_src;
    logic [31:0] branch_addr;
    logic        id_ex_reg_write;
    logic        id_ex_mem_to_reg;
    logic        id_ex_mem_read;
    logic        id_ex_mem_write;
    logic        id_ex_alu_src;
    logic        id_ex_reg_dst;
    logic [1:0]  id_ex_alu_op;
    logic [31:0] id_ex_read_data_1;
    logic [31:0] id_ex_read_data_2;
    logic [31:0] id_ex_imm_ext;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [31:0] id_ex_pc_plus_four;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_byp;

    id_stage dut (
        .clk                (clk),
        .rst                (rst),
        .if_instruction     (if_instruction),
        .if_pc_plus_four    (if_pc_plus_four),
        .wb_reg_write       (wb_reg_write),
        .wb_write_reg       (wb_write_reg),
        .wb_write_data      (wb_write_data),
        .ex_mem_mem_read    (ex_mem_mem_read),
        .ex_mem_rd          (ex_mem_rd),
        .pc_write           (pc_write),
        .pc_src             (pc_src),
        .branch_addr        (branch_addr),
        .id_ex_reg_write    (id_ex_reg_write),
        .id_ex_mem_to_reg   (id_ex_mem_to_reg),
        .id_ex_mem_read     (id_ex_mem_read),
        .id_ex_mem_write    (id_ex_mem_write),
        .id_ex_alu_src      (id_ex_alu_src),
        .id_ex_reg_dst      (id_ex_reg_dst),
        .id_ex_alu_op       (id_ex_alu_op),
        .id_ex_read_data_1  (id_ex_read_data_1),
        .id_ex_read_data_2  (id_ex_read_data_2),
        .id_ex_imm_ext      (id_ex_imm_ext),
        .id_ex_rs           (id_ex_rs),
        .id_ex_rt           (id_ex_rt),
        .id_ex_rd           (id_ex_rd),
        .id_ex_pc_plus_four (id_ex_pc_plus_four)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write  = en;
        wb_write_reg  = r;
        wb_write_data = d;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_ctrl"}, {24'd0, id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read,
            id_ex_mem_write, id_ex_alu_src, id_ex_reg_dst, id_ex_alu_op}, 32'd0);
        chk({tag, "_rd1"}, id_ex_read_data_1, 32'd0);
        chk({tag, "_rd2"}, id_ex_read_data_2, 32'd0);
        chk({tag, "_imm"}, id_ex_imm_ext, 32'd0);
        chk({tag, "_regs"}, {17'd0, id_ex_rs, id_ex_rt, id_ex_rd}, 32'd0);
        chk({tag, "_pc4"}, id_ex_pc_plus_four, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        if_instruction = 32'd0;
        if_pc_plus_four = 32'd0;
        wb(1'b0, 5'd0, 32'd0);
        ex_mem_mem_read = 1'b0;
        ex_mem_rd = 5'd0;

        // reset
        tick(); tick();
        rst = 1'b0;
        chk_bubble("rst");
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_pc_src", {31'd0, pc_src}, 32'd0);

        // WB r5, then add r3,r5,r0
        wb(1'b1, 5'd5, 32'h0000_1234);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        if_instruction = I_ADD_R3_R5_R0; if_pc_plus_four = 32'h4;
        tick();
        if_instruction = 32'd0; if_pc_plus_four = 32'd0;
        tick();
        chk("add_rd1", id_ex_read_data_1, 32'h0000_1234);
        chk("add_reg_dst", {31'd0, id_ex_reg_dst}, 32'd1);
        chk("add_reg_write", {31'd0, id_ex_reg_write}, 32'd1);
        chk("add_alu_op", {30'd0, id_ex_alu_op}, 32'd2);
        chk("add_alu_src", {31'd0, id_ex_alu_src}, 32'd0);
        chk("add_rd", {27'd0, id_ex_rd}, 32'd3);
        chk("add_pc4", id_ex_pc_plus_four, 32'h4);

        // same-cycle WB r7 while sub r1,r7,r0 is in ID
        if_instruction = I_SUB_R1_R7_R0;
        tick();
        wb(1'b1, 5'd7, 32'hDEAD_BEEF);
        if_instruction = 32'd0;
        tick();
        wb(1'b0, 5'd0, 32'd0);
`ifdef ID_REGFILE_BYPASS_EN
        exp_byp = 32'hDEAD_BEEF;
`else
        exp_byp = 32'h0000_0000;
`endif
        chk("sub_wb_same_cycle", id_ex_read_data_1, exp_byp);

        // load-use: lw r2 then add r4,r2,r3
        if_instruction = I_LW_R2_0_R1;
        tick();
        if_instruction = I_ADD_R4_R2_R3;
        tick();
        chk("lu_stall_pc_write", {31'd0, pc_write}, 32'd0);
        chk("lu_stall_pc_src", {31'd0, pc_src}, 32'd0);
        chk("lw_ctrl", {27'd0, id_ex_mem_read, id_ex_mem_to_reg, id_ex_alu_src, id_ex_reg_write, id_ex_mem_write}, 32'b11110);
        chk("lw_rt", {27'd0, id_ex_rt}, 32'd2);
        tick();
        chk_bubble("lu_bubble");
        chk("lu_resume_pc_write", {31'd0, pc_write}, 32'd1);
        if_instruction = 32'd0;
        tick();
        chk("lu_add_regs", {17'd0, id_ex_rs, id_ex_rt, id_ex_rd}, {17'd0, 5'd2, 5'd3, 5'd4});
        chk("lu_add_reg_dst", {31'd0, id_ex_reg_dst}, 32'd1);

        // taken beq r1,r2,+3 with r1=r2=5
        wb(1'b1, 5'd1, 32'd5); tick();
        wb(1'b1, 5'd2, 32'd5); tick();
        wb(1'b0, 5'd0, 32'd0);
        if_instruction = I_BEQ_R1_R2_3; if_pc_plus_four = 32'h10;
        tick();
        chk("beq_taken_pc_src", {31'd0, pc_src}, 32'd1);
        chk("beq_branch_addr", branch_addr, 32'h0000_001C);
        chk("beq_taken_pc_write", {31'd0, pc_write}, 32'd1);
        if_instruction = I_ADDI_R9_7; if_pc_plus_four = 32'h14;
        tick();
        chk("beq_idex_alu_op", {30'd0, id_ex_alu_op}, 32'd1);
        chk("beq_idex_imm", id_ex_imm_ext, 32'd3);
        chk("beq_idex_regs", {22'd0, id_ex_rs, id_ex_rt}, {22'd0, 5'd1, 5'd2});
        chk("beq_idex_pc4", id_ex_pc_plus_four, 32'h10);
        chk("beq_flush_pc_src", {31'd0, pc_src}, 32'd0);
        if_instruction = 32'd0; if_pc_plus_four = 32'd0;
        tick();
        chk("flush_nop_alu_src", {31'd0, id_ex_alu_src}, 32'd0);
        chk("flush_nop_rt", {27'd0, id_ex_rt}, 32'd0);
        chk("flush_nop_imm", id_ex_imm_ext, 32'd0);

        // not-taken beq with r2=6, then ex_mem load hazard on beq
        wb(1'b1, 5'd2, 32'd6); tick();
        wb(1'b0, 5'd0, 32'd0);
        if_instruction = I_BEQ_R1_R2_3; if_pc_plus_four = 32'h10;
        tick();
        chk("beq_nt_pc_src", {31'd0, pc_src}, 32'd0);
        chk("beq_nt_branch_addr", branch_addr, 32'h0000_001C);
        ex_mem_mem_read = 1'b1; ex_mem_rd = 5'd2;
        #1;
        chk("beq_exmem_stall", {31'd0, pc_write}, 32'd0);
        ex_mem_mem_read = 1'b0; ex_mem_rd = 5'd0;
        #1;
        chk("beq_exmem_clear", {31'd0, pc_write}, 32'd1);
        if_instruction = 32'd0; if_pc_plus_four = 32'd0;
        tick();

        // addi r1 then beq r1,r0: one-cycle branch hazard stall
        wb(1'b1, 5'd1, 32'd0); tick();
        wb(1'b0, 5'd0, 32'd0);
        if_instruction = I_ADDI_R1_4;
        tick();
        if_instruction = I_BEQ_R1_R0_1; if_pc_plus_four = 32'h20;
        tick();
        chk("bh_stall_pc_write", {31'd0, pc_write}, 32'd0);
        chk("bh_stall_pc_src", {31'd0, pc_src}, 32'd0);
        tick();
        chk("bh_bubble_reg_write", {31'd0, id_ex_reg_write}, 32'd0);
        chk("bh_resume_pc_write", {31'd0, pc_write}, 32'd1);
        chk("bh_resume_pc_src", {31'd0, pc_src}, 32'd1);
        chk("bh_branch_addr", branch_addr, 32'h0000_0024);
        if_instruction = 32'd0; if_pc_plus_four = 32'd0;
        tick();

        // r0 write ignored, including a same-cycle write
        if_instruction = I_ADD_R6_R0_R0;
        tick();
        wb(1'b1, 5'd0, 32'h0000_FFFF);
        if_instruction = 32'd0;
        tick();
        wb(1'b0, 5'd0, 32'd0);
        chk("r0_same_rd1", id_ex_read_data_1, 32'd0);
        chk("r0_same_rd2", id_ex_read_data_2, 32'd0);
        chk("r0_same_rd", {27'd0, id_ex_rd}, 32'd6);
        if_instruction = I_ADD_R6_R0_R0;
        tick();
        if_instruction = 32'd0;
        tick();
        chk("r0_after_rd1", id_ex_read_data_1, 32'd0);

        // reset during a load-use stall
        if_instruction = I_LW_R2_0_R1;
        tick();
        if_instruction = I_ADD_R4_R2_R3;
        tick();
        chk("rs_stall_pc_write", {31'd0, pc_write}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_instruction = 32'd0;
        chk_bubble("rst_in_stall");
        chk("rst_in_stall_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_in_stall_pc_src", {31'd0, pc_src}, 32'd0);
        if_instruction = I_ADD_R3_R5_R0;
        tick();
        if_instruction = 32'd0;
        tick();
        chk("rst_cleared_r5", id_ex_read_data_1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
